// File: rtl/neighbor_scan_pkg.sv
// Shared definitions for the neighbour-scan stage and the random stages around it.
// Holds the scan state encoding, the Galois LFSR polynomial and its default seed.
package neighbor_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Right-shifting Galois step; a nonzero state never maps to zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
  endfunction

endpackage

// File: rtl/neighbor_scan_lfsr16.sv
// Free-running 16-bit Galois LFSR, one step per clock; reset loads SEED (must be nonzero).
// Shared by the random-selection stages.
module lfsr16
  import neighbor_scan_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clock,
  input  logic        nrst,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge clock) begin
    if (!nrst) r_q <= SEED;
    else       r_q <= lfsr_step(r_q);
  end

  assign q = r_q;

endmodule

// File: rtl/neighbor_scan.sv
// Scans neighbour costs from a 1-cycle-latency cost RAM, compacts better indices into a list RAM,
// then holds the count and a random `which`. Build option ACCEPT_EQUAL_EN: equal cost counts as better.
module neighbor_scan
  import neighbor_scan_pkg::*;
#(
  parameter int          COST_W    = 16,
  parameter int          IDX_W     = 16,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic              clock,
  input  logic              nrst,
  input  logic              start_scan,
  input  logic [IDX_W-1:0]  neighbor_total,
  input  logic [COST_W-1:0] current_cost,
  output logic [IDX_W-1:0]  cost_rd_addr,
  input  logic [COST_W-1:0] cost_rd_data,
  output logic              list_wr_en,
  output logic [IDX_W-1:0]  list_wr_addr,
  output logic [IDX_W-1:0]  list_wr_data,
  output logic [IDX_W-1:0]  betterNeighborCount,
  output logic [IDX_W-1:0]  which,
  output logic              done_scan
);

  scan_state_t       r_state;
  scan_state_t       w_next_state;

  logic [IDX_W-1:0]  r_total;
  logic [COST_W-1:0] r_cur;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_idx_d;
  logic              r_rd_valid;
  logic [IDX_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_last_addr;
  logic [IDX_W-1:0]  r_better_count;
  logic [IDX_W-1:0]  r_which;

  logic              w_start;
  logic              w_scanning;
  logic              w_done;
  logic              w_cmp;
  logic              w_better;
  logic              w_enter_done;
  logic [IDX_W-1:0]  w_final_count;
  logic [15:0]       w_lfsr_q;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .nrst  (nrst),
    .q     (w_lfsr_q)
  );

  always_ff @(posedge clock) begin
    if (!nrst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_scan) w_next_state = (neighbor_total == '0) ? ST_DONE : ST_SCAN;
      end
      ST_SCAN: begin
        if (r_idx == r_total - IDX_W'(1)) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: w_next_state = ST_DONE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start      = 1'b0;
    w_scanning   = 1'b0;
    w_done       = 1'b0;
    cost_rd_addr = r_last_addr;
    case (r_state)
      ST_IDLE: w_start = start_scan;
      ST_SCAN: begin
        w_scanning   = 1'b1;
        cost_rd_addr = r_idx;
      end
      ST_DONE: begin
        w_start = start_scan;
        w_done  = 1'b1;
      end
      default: ;
    endcase
  end

  // Data returned this cycle belongs to the address issued last cycle (r_idx_d).
`ifdef ACCEPT_EQUAL_EN
  assign w_cmp = (cost_rd_data <= r_cur);
`else
  assign w_cmp = (cost_rd_data < r_cur);
`endif
  assign w_better = r_rd_valid & w_cmp;

  // A restart from DONE with total==0 re-enters DONE and must recapture too.
  assign w_enter_done  = (w_next_state == ST_DONE) && ((r_state != ST_DONE) || w_start);
  assign w_final_count = w_start ? '0 : (r_count + IDX_W'(w_better));

  always_ff @(posedge clock) begin
    if (!nrst) begin
      r_total        <= '0;
      r_cur          <= '0;
      r_idx          <= '0;
      r_idx_d        <= '0;
      r_rd_valid     <= 1'b0;
      r_count        <= '0;
      r_last_addr    <= '0;
      r_better_count <= '0;
      r_which        <= '0;
    end else begin
      r_rd_valid <= w_scanning;
      r_idx_d    <= r_idx;
      if (w_start) begin
        r_total <= neighbor_total;
        r_cur   <= current_cost;
        r_idx   <= '0;
        r_count <= '0;
      end else begin
        if (w_scanning) begin
          r_idx       <= r_idx + IDX_W'(1);
          r_last_addr <= r_idx;
        end
        if (w_better) r_count <= r_count + IDX_W'(1);
      end
      if (w_enter_done) begin
        r_better_count <= w_final_count;
        r_which        <= IDX_W'(w_lfsr_q);
      end
    end
  end

  assign list_wr_en          = w_better;
  assign list_wr_addr        = r_count;
  assign list_wr_data        = r_idx_d;
  assign betterNeighborCount = r_better_count;
  assign which               = r_which;
  assign done_scan           = w_done;

endmodule

// File: tb/tb_neighbor_scan.sv
// Directed bench for neighbor_scan: cost RAM model, list-write monitor and an LFSR reference
// for `which`; expectations follow the ACCEPT_EQUAL_EN build option.
module tb_neighbor_scan;

  logic        clock = 1'b0;
  logic        nrst;
  logic        start_scan;
  logic [15:0] neighbor_total;
  logic [15:0] current_cost;
  logic [15:0] cost_rd_addr;
  logic [15:0] cost_rd_data = '0;
  logic        list_wr_en;
  logic [15:0] list_wr_addr;
  logic [15:0] list_wr_data;
  logic [15:0] betterNeighborCount;
  logic [15:0] which;
  logic        done_scan;

  logic [15:0] mem [16];
  int          wa[$];
  int          wd[$];
  int          bad_wr = 0;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          last_cnt = 0;
  logic [15:0] m_lfsr = 16'h0;
  logic [15:0] m_prev = 16'h0;
  int          exp_d [16];

  neighbor_scan dut (
    .clock               (clock),
    .nrst                (nrst),
    .start_scan          (start_scan),
    .neighbor_total      (neighbor_total),
    .current_cost        (current_cost),
    .cost_rd_addr        (cost_rd_addr),
    .cost_rd_data        (cost_rd_data),
    .list_wr_en          (list_wr_en),
    .list_wr_addr        (list_wr_addr),
    .list_wr_data        (list_wr_data),
    .betterNeighborCount (betterNeighborCount),
    .which               (which),
    .done_scan           (done_scan)
  );

  always #5 clock = ~clock;

  // Synchronous-read cost RAM: data for an address appears one cycle later.
  always @(posedge clock) cost_rd_data <= mem[cost_rd_addr[3:0]];

  // Reference LFSR; m_prev is the value the DUT LFSR held before the latest edge.
  always @(posedge clock) begin
    m_prev <= m_lfsr;
    if (!nrst) m_lfsr <= 16'hACE1;
    else       m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  always @(negedge clock) begin
    if (list_wr_en) begin
      wa.push_back(int'(list_wr_addr));
      wd.push_back(int'(list_wr_data));
      if (done_scan) bad_wr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_scan(input string tag, input int total, input logic [15:0] cur, input int n_exp);
    int lat;
    @(negedge clock);
    start_scan     = 1'b1;
    neighbor_total = 16'(total);
    current_cost   = cur;
    wa.delete();
    wd.delete();
    @(negedge clock);
    start_scan = 1'b0;
    lat        = 1;
    if (total > 0) begin
      chk({tag, "_drop"}, done_scan, 1'b0);
      chk({tag, "_hold"}, betterNeighborCount, last_cnt);
    end
    while (!done_scan && lat < 300) begin
      @(negedge clock);
      lat++;
    end
    chk({tag, "_lat"}, lat, (total == 0) ? 1 : total + 2);
    chk({tag, "_cnt"}, betterNeighborCount, n_exp);
    chk({tag, "_which"}, which, m_prev);
    chk({tag, "_nwr"}, wa.size(), n_exp);
    for (int i = 0; i < n_exp && i < wa.size(); i++) begin
      chk($sformatf("%s_wa%0d", tag, i), wa[i], i);
      chk($sformatf("%s_wd%0d", tag, i), wd[i], exp_d[i]);
    end
    if (total > 0) chk({tag, "_addr_hold"}, cost_rd_addr, total - 1);
    last_cnt = n_exp;
  endtask

  initial begin
    int n;
    nrst           = 1'b0;
    start_scan     = 1'b0;
    neighbor_total = '0;
    current_cost   = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    repeat (2) @(negedge clock);
    chk("rst_done",  done_scan, 1'b0);
    chk("rst_cnt",   betterNeighborCount, 0);
    chk("rst_which", which, 0);
    chk("rst_wren",  list_wr_en, 1'b0);
    chk("rst_addr",  cost_rd_addr, 0);
    chk("rst_waddr", list_wr_addr, 0);
    chk("rst_wdata", list_wr_data, 0);
    nrst = 1'b1;

    mem[0] = 16'd12; mem[1] = 16'd5; mem[2] = 16'd10; mem[3] = 16'd3;
`ifdef ACCEPT_EQUAL_EN
    exp_d[0] = 1; exp_d[1] = 2; exp_d[2] = 3; n = 3;
`else
    exp_d[0] = 1; exp_d[1] = 3; n = 2;
`endif
    run_scan("t4", 4, 16'd10, n);

    run_scan("t0", 0, 16'd10, 0);

    for (int i = 0; i < 8; i++) begin
      mem[i]   = 16'd0;
      exp_d[i] = i;
    end
    run_scan("t8", 8, 16'd1, 8);
    run_scan("t8r", 8, 16'd1, 8);

    // Reset in the middle of a scan.
    @(negedge clock);
    start_scan     = 1'b1;
    neighbor_total = 16'd8;
    current_cost   = 16'd1;
    @(negedge clock);
    start_scan = 1'b0;
    n = 0;
    while (cost_rd_addr != 16'd3 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("mid_reach3", cost_rd_addr, 3);
    nrst = 1'b0;
    @(negedge clock);
    chk("mid_done",  done_scan, 1'b0);
    chk("mid_cnt",   betterNeighborCount, 0);
    chk("mid_which", which, 0);
    chk("mid_wren",  list_wr_en, 1'b0);
    chk("mid_addr",  cost_rd_addr, 0);
    nrst     = 1'b1;
    last_cnt = 0;

    mem[0] = 16'd5;  mem[1] = 16'd20; mem[2] = 16'd1; mem[3] = 16'd9;
    mem[4] = 16'd30; mem[5] = 16'd2;  mem[6] = 16'd7; mem[7] = 16'd40;
`ifdef ACCEPT_EQUAL_EN
    exp_d[0] = 0; exp_d[1] = 2; exp_d[2] = 3; exp_d[3] = 5; exp_d[4] = 6; n = 5;
`else
    exp_d[0] = 0; exp_d[1] = 2; exp_d[2] = 5; exp_d[3] = 6; n = 4;
`endif
    run_scan("t6", 8, 16'd9, n);

    repeat (3) @(negedge clock);
    chk("done_stable", done_scan, 1'b1);
    chk("wr_in_done", bad_wr, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
